// File: rtl/cfg_regbank_pkg.sv
// Shared definitions for the double-buffered sensor configuration register bank.
package cfg_regbank_pkg;

  // Commit controller states. ST_XFER is folded into the FRAME_SYNC edge, so
  // the controller only passes through it while recovering from a bad state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_XFER  = 2'd2
  } fsm_state_e;

  // Update policies.
  localparam int SYNC_IMMEDIATE = 0;
  localparam int SYNC_FRAME     = 1;

  // Field positions inside a sensor config word. Consumers slice ACTIVE with these.
  localparam int MCLK_SPEED_BIT = 0;
  localparam int IDLE_MODE_BIT  = 1;
  localparam int MCLK_MODE_LSB  = 6;
  localparam int MCLK_MODE_W    = 2;
  localparam int ROWS_DELAY_LSB = 11;
  localparam int ROWS_DELAY_W   = 5;

endpackage

// File: rtl/cfg_regbank_if.sv
// Host byte-write / word-read bus plus commit control and active-bank export.
interface cfg_regbank_if #(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 16,
  parameter int ADDR_A_W = 3,
  parameter int ADDR_B_W = 2
);
  logic                      WE_A;
  logic [ADDR_A_W-1:0]       ADD_A;
  logic [7:0]                DAT_A;
  logic                      RE_B;
  logic                      SEL_B;
  logic [ADDR_B_W-1:0]       ADD_B;
  logic [REG_W-1:0]          DAT_B;
  logic                      VALID_B;
  logic                      COMMIT;
  logic                      FRAME_SYNC;
  logic                      ARMED;
  logic                      UPDATED;
  logic [NUM_REGS-1:0]       DIRTY;
  logic [NUM_REGS*REG_W-1:0] ACTIVE;

  modport master (
    output WE_A, ADD_A, DAT_A, RE_B, SEL_B, ADD_B, COMMIT, FRAME_SYNC,
    input  DAT_B, VALID_B, ARMED, UPDATED, DIRTY, ACTIVE
  );

  modport slave (
    input  WE_A, ADD_A, DAT_A, RE_B, SEL_B, ADD_B, COMMIT, FRAME_SYNC,
    output DAT_B, VALID_B, ARMED, UPDATED, DIRTY, ACTIVE
  );
endinterface

// File: rtl/cfg_regbank_sync_commit_fsm.sv
// Commit controller: decides when staged words move to the active bank.
module cfg_commit_fsm
  import cfg_regbank_pkg::*;
#(
  parameter int SYNC_MODE = SYNC_FRAME
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic commit_i,
  input  logic frame_sync_i,
  input  logic dirty_any_i,
  output logic xfer_en_o,
  output logic updated_o,
  output logic armed_o
);
  fsm_state_e state_q;
  logic       updated_q;

  // Transfer happens on the edge that samples FRAME_SYNC (armed, or commit+sync together);
  // in immediate mode any dirty word transfers on the next edge.
  always_comb begin
    xfer_en_o = 1'b0;
    if (SYNC_MODE == SYNC_IMMEDIATE)
      xfer_en_o = dirty_any_i;
    else
      xfer_en_o = frame_sync_i &&
                  ((state_q == ST_ARMED) || ((state_q == ST_IDLE) && commit_i));
  end

  // State register plus registered UPDATED pulse, one cycle after the transfer edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      updated_q <= 1'b0;
    end else begin
      updated_q <= xfer_en_o;
      case (state_q)
        ST_IDLE:  if ((SYNC_MODE == SYNC_FRAME) && commit_i && !frame_sync_i)
                    state_q <= ST_ARMED;
        ST_ARMED: if (frame_sync_i)
                    state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign updated_o = updated_q;
  assign armed_o   = (state_q == ST_ARMED);
endmodule

// File: rtl/cfg_regbank_sync.sv
// Double-buffered config register bank: host writes bytes into staging, words
// move to the active bank immediately or on a frame-synchronous commit.
module cfg_regbank_sync
  import cfg_regbank_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int REG_W     = 16,
  parameter int ADDR_A_W  = 3,
  parameter int ADDR_B_W  = 2,
  parameter int SYNC_MODE = SYNC_FRAME,
  parameter logic [NUM_REGS*REG_W-1:0] RESET_VAL = '0
) (
  input logic          CLOCK,
  input logic          RESET_N,
  cfg_regbank_if.slave bus
);
  localparam int BYTES = REG_W / 8;

  logic [NUM_REGS-1:0][REG_W-1:0] stage_q, stage_d;
  logic [NUM_REGS-1:0][REG_W-1:0] act_q, act_d;
  logic [NUM_REGS-1:0]            dirty_q, dirty_d, wr_hit;
  logic [REG_W-1:0]               dat_b_q, dat_b_d;
  logic                           valid_b_q;
  logic [ADDR_A_W-1:0]            add_a;
  logic [ADDR_B_W-1:0]            add_b;
  logic                           xfer_en;
  logic                           updated;
  logic                           armed;

  assign add_a = bus.ADD_A;
  assign add_b = bus.ADD_B;

  // Byte write into staging; lane 0 is the most significant byte, out-of-range words drop.
  always_comb begin
    int w_idx;
    int l_idx;
    stage_d = stage_q;
    wr_hit  = '0;
    w_idx   = int'(add_a) / BYTES;
    l_idx   = int'(add_a) % BYTES;
    for (int w = 0; w < NUM_REGS; w++) begin
      if (bus.WE_A && (w_idx == w)) begin
        wr_hit[w] = 1'b1;
        for (int l = 0; l < BYTES; l++)
          if (l_idx == l) stage_d[w][(BYTES-1-l)*8 +: 8] = bus.DAT_A;
      end
    end
  end

  // Transfer copies pre-edge staging of dirty words; a same-cycle write re-dirties its word.
  always_comb begin
    act_d   = act_q;
    dirty_d = dirty_q;
    for (int w = 0; w < NUM_REGS; w++) begin
      if (xfer_en && dirty_q[w]) begin
        act_d[w]   = stage_q[w];
        dirty_d[w] = 1'b0;
      end
    end
    dirty_d = dirty_d | wr_hit;
  end

  // Word read from either bank using pre-edge contents; out-of-range reads return zero.
  always_comb begin
    int b_idx;
    b_idx   = int'(add_b);
    dat_b_d = dat_b_q;
    if (bus.RE_B) begin
      dat_b_d = '0;
      for (int w = 0; w < NUM_REGS; w++)
        if (b_idx == w) dat_b_d = bus.SEL_B ? stage_q[w] : act_q[w];
    end
  end

  // Bank, dirty and read-port registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stage_q   <= RESET_VAL;
      act_q     <= RESET_VAL;
      dirty_q   <= '0;
      dat_b_q   <= '0;
      valid_b_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      act_q     <= act_d;
      dirty_q   <= dirty_d;
      dat_b_q   <= dat_b_d;
      valid_b_q <= bus.RE_B;
    end
  end

  cfg_commit_fsm #(
    .SYNC_MODE (SYNC_MODE)
  ) u_commit (
    .clk_i        (CLOCK),
    .rst_n_i      (RESET_N),
    .commit_i     (bus.COMMIT),
    .frame_sync_i (bus.FRAME_SYNC),
    .dirty_any_i  (|dirty_q),
    .xfer_en_o    (xfer_en),
    .updated_o    (updated),
    .armed_o      (armed)
  );

  assign bus.DAT_B   = dat_b_q;
  assign bus.VALID_B = valid_b_q;
  assign bus.ARMED   = armed;
  assign bus.UPDATED = updated;
  assign bus.DIRTY   = dirty_q;
  assign bus.ACTIVE  = act_q;
endmodule

// File: tb/tb_cfg_regbank_sync.sv
// Directed bench: frame-sync build driven from a vector table, plus short
// sequences on a 3-word build, an immediate-mode build and async reset.
module tb_cfg_regbank_sync;
  import cfg_regbank_pkg::*;

  localparam logic [63:0] RV0 = {16'h0000, 16'h0000, 16'h8841, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cfg_regbank_if #(.NUM_REGS(4), .REG_W(16), .ADDR_A_W(3), .ADDR_B_W(2)) bus0 ();
  cfg_regbank_if #(.NUM_REGS(3), .REG_W(16), .ADDR_A_W(3), .ADDR_B_W(2)) bus1 ();
  cfg_regbank_if #(.NUM_REGS(4), .REG_W(16), .ADDR_A_W(3), .ADDR_B_W(2)) bus2 ();

  cfg_regbank_sync #(.NUM_REGS(4), .REG_W(16), .ADDR_A_W(3), .ADDR_B_W(2),
                     .SYNC_MODE(SYNC_FRAME), .RESET_VAL(RV0))
    u0 (.CLOCK(clk), .RESET_N(rst_n), .bus(bus0.slave));
  cfg_regbank_sync #(.NUM_REGS(3), .REG_W(16), .ADDR_A_W(3), .ADDR_B_W(2),
                     .SYNC_MODE(SYNC_FRAME), .RESET_VAL(48'h0))
    u1 (.CLOCK(clk), .RESET_N(rst_n), .bus(bus1.slave));
  cfg_regbank_sync #(.NUM_REGS(4), .REG_W(16), .ADDR_A_W(3), .ADDR_B_W(2),
                     .SYNC_MODE(SYNC_IMMEDIATE), .RESET_VAL(64'h0))
    u2 (.CLOCK(clk), .RESET_N(rst_n), .bus(bus2.slave));

  typedef struct {
    logic        we;
    logic [2:0]  aa;
    logic [7:0]  da;
    logic        re;
    logic        sel;
    logic [1:0]  ab;
    logic        cm;
    logic        fs;
    logic [15:0] e_dat;
    logic        e_vld;
    logic        e_arm;
    logic        e_upd;
    logic [3:0]  e_dirty;
    logic [63:0] e_act;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    bus0.WE_A = 0; bus0.ADD_A = 0; bus0.DAT_A = 0; bus0.RE_B = 0; bus0.SEL_B = 0;
    bus0.ADD_B = 0; bus0.COMMIT = 0; bus0.FRAME_SYNC = 0;
    bus1.WE_A = 0; bus1.ADD_A = 0; bus1.DAT_A = 0; bus1.RE_B = 0; bus1.SEL_B = 0;
    bus1.ADD_B = 0; bus1.COMMIT = 0; bus1.FRAME_SYNC = 0;
    bus2.WE_A = 0; bus2.ADD_A = 0; bus2.DAT_A = 0; bus2.RE_B = 0; bus2.SEL_B = 0;
    bus2.ADD_B = 0; bus2.COMMIT = 0; bus2.FRAME_SYNC = 0;
  endtask

  initial begin
    logic [63:0] a1, a2, a3;
    a1 = {16'h0000, 16'h0000, 16'hA53C, 16'h0000};
    a2 = {16'h0000, 16'h0000, 16'hA511, 16'h0000};
    a3 = {16'h0000, 16'h0000, 16'hA5FF, 16'h0000};
    //          we aa    da     re sel ab   cm fs  dat       vld arm upd dirty    act
    vt[0]  = '{1, 3'd2, 8'hA5, 0, 0, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 4'b0010, RV0};
    vt[1]  = '{1, 3'd3, 8'h3C, 0, 0, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 4'b0010, RV0};
    vt[2]  = '{0, 3'd0, 8'h00, 1, 1, 2'd1, 0, 0, 16'hA53C, 1, 0, 0, 4'b0010, RV0};
    vt[3]  = '{0, 3'd0, 8'h00, 1, 0, 2'd1, 0, 0, 16'h8841, 1, 0, 0, 4'b0010, RV0};
    vt[4]  = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 0, 16'h8841, 0, 0, 0, 4'b0010, RV0};
    vt[5]  = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 1, 0, 16'h8841, 0, 1, 0, 4'b0010, RV0};
    vt[6]  = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 0, 16'h8841, 0, 1, 0, 4'b0010, RV0};
    vt[7]  = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 0, 16'h8841, 0, 1, 0, 4'b0010, RV0};
    vt[8]  = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 0, 16'h8841, 0, 1, 0, 4'b0010, RV0};
    vt[9]  = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 1, 16'h8841, 0, 0, 1, 4'b0000, a1};
    vt[10] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 0, 16'h8841, 0, 0, 0, 4'b0000, a1};
    vt[11] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 1, 16'h8841, 0, 0, 0, 4'b0000, a1};
    vt[12] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 1, 0, 16'h8841, 0, 1, 0, 4'b0000, a1};
    vt[13] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 1, 0, 16'h8841, 0, 1, 0, 4'b0000, a1};
    vt[14] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 0, 1, 16'h8841, 0, 0, 1, 4'b0000, a1};
    vt[15] = '{1, 3'd3, 8'h11, 0, 0, 2'd0, 0, 0, 16'h8841, 0, 0, 0, 4'b0010, a1};
    vt[16] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 1, 0, 16'h8841, 0, 1, 0, 4'b0010, a1};
    vt[17] = '{1, 3'd3, 8'hFF, 0, 0, 2'd0, 0, 1, 16'h8841, 0, 0, 1, 4'b0010, a2};
    vt[18] = '{0, 3'd0, 8'h00, 1, 1, 2'd1, 0, 0, 16'hA5FF, 1, 0, 0, 4'b0010, a2};
    vt[19] = '{0, 3'd0, 8'h00, 1, 0, 2'd1, 0, 0, 16'hA511, 1, 0, 0, 4'b0010, a2};
    vt[20] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 1, 1, 16'hA511, 0, 0, 1, 4'b0000, a3};
    vt[21] = '{1, 3'd7, 8'h12, 0, 0, 2'd0, 0, 0, 16'hA511, 0, 0, 0, 4'b1000, a3};
    vt[22] = '{0, 3'd0, 8'h00, 1, 1, 2'd3, 0, 0, 16'h0012, 1, 0, 0, 4'b1000, a3};
    vt[23] = '{0, 3'd0, 8'h00, 0, 0, 2'd0, 1, 0, 16'h0012, 0, 1, 0, 4'b1000, a3};

    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst.act1",  64'(bus0.ACTIVE[31:16]), 64'h8841);
    chk("rst.dirty", 64'(bus0.DIRTY), 64'h0);
    chk("rst.dat",   64'(bus0.DAT_B), 64'h0);
    chk("rst.vld",   64'(bus0.VALID_B), 64'h0);
    chk("rst.arm",   64'(bus0.ARMED), 64'h0);
    chk("rst.upd",   64'(bus0.UPDATED), 64'h0);
    chk("rst.mclk_speed", 64'(bus0.ACTIVE[16+MCLK_SPEED_BIT]), 64'h1);
    chk("rst.idle_mode",  64'(bus0.ACTIVE[16+IDLE_MODE_BIT]), 64'h0);
    chk("rst.mclk_mode",  64'(bus0.ACTIVE[16+MCLK_MODE_LSB +: MCLK_MODE_W]), 64'h1);
    chk("rst.rows_delay", 64'(bus0.ACTIVE[16+ROWS_DELAY_LSB +: ROWS_DELAY_W]), 64'd17);

    // frame-sync build: table of one-cycle vectors
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus0.WE_A = vt[i].we; bus0.ADD_A = vt[i].aa; bus0.DAT_A = vt[i].da;
      bus0.RE_B = vt[i].re; bus0.SEL_B = vt[i].sel; bus0.ADD_B = vt[i].ab;
      bus0.COMMIT = vt[i].cm; bus0.FRAME_SYNC = vt[i].fs;
      @(posedge clk); #1;
      chk($sformatf("row%0d.dat", i),   64'(bus0.DAT_B),   64'(vt[i].e_dat));
      chk($sformatf("row%0d.vld", i),   64'(bus0.VALID_B), 64'(vt[i].e_vld));
      chk($sformatf("row%0d.arm", i),   64'(bus0.ARMED),   64'(vt[i].e_arm));
      chk($sformatf("row%0d.upd", i),   64'(bus0.UPDATED), 64'(vt[i].e_upd));
      chk($sformatf("row%0d.dirty", i), 64'(bus0.DIRTY),   64'(vt[i].e_dirty));
      chk($sformatf("row%0d.act", i),   bus0.ACTIVE,       vt[i].e_act);
    end
    @(negedge clk);
    idle_all();

    // 3-word build: writes and reads past the last word
    bus1.WE_A = 1; bus1.ADD_A = 3'd4; bus1.DAT_A = 8'h77;
    @(posedge clk); #1;
    chk("n3.wr4.dirty", 64'(bus1.DIRTY), 64'h4);
    @(negedge clk);
    bus1.ADD_A = 3'd7; bus1.DAT_A = 8'h12;
    @(posedge clk); #1;
    chk("n3.wr7.dirty", 64'(bus1.DIRTY), 64'h4);
    @(negedge clk);
    bus1.WE_A = 0; bus1.RE_B = 1; bus1.SEL_B = 1; bus1.ADD_B = 2'd2;
    @(posedge clk); #1;
    chk("n3.rd2.dat", 64'(bus1.DAT_B), 64'h7700);
    chk("n3.rd2.vld", 64'(bus1.VALID_B), 64'h1);
    @(negedge clk);
    bus1.ADD_B = 2'd3;
    @(posedge clk); #1;
    chk("n3.rd3.dat", 64'(bus1.DAT_B), 64'h0);
    chk("n3.rd3.vld", 64'(bus1.VALID_B), 64'h1);
    chk("n3.act", 64'(bus1.ACTIVE), 64'h0);
    @(negedge clk);
    idle_all();

    // immediate-mode build
    bus2.WE_A = 1; bus2.ADD_A = 3'd0; bus2.DAT_A = 8'h55;
    @(posedge clk); #1;
    chk("imm.w.act0",  64'(bus2.ACTIVE[15:0]), 64'h0);
    chk("imm.w.dirty", 64'(bus2.DIRTY), 64'h1);
    chk("imm.w.upd",   64'(bus2.UPDATED), 64'h0);
    @(negedge clk);
    bus2.WE_A = 0; bus2.COMMIT = 1;
    @(posedge clk); #1;
    chk("imm.x.act0",  64'(bus2.ACTIVE[15:0]), 64'h5500);
    chk("imm.x.upd",   64'(bus2.UPDATED), 64'h1);
    chk("imm.x.dirty", 64'(bus2.DIRTY), 64'h0);
    chk("imm.x.arm",   64'(bus2.ARMED), 64'h0);
    @(negedge clk);
    bus2.COMMIT = 0;
    @(posedge clk); #1;
    chk("imm.y.upd", 64'(bus2.UPDATED), 64'h0);
    chk("imm.y.arm", 64'(bus2.ARMED), 64'h0);

    // asynchronous reset while armed (frame-sync build left armed by the table)
    @(negedge clk);
    chk("pre.arm", 64'(bus0.ARMED), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.arm",   64'(bus0.ARMED), 64'h0);
    chk("arst.act",   bus0.ACTIVE, RV0);
    chk("arst.dirty", 64'(bus0.DIRTY), 64'h0);
    chk("arst.dat",   64'(bus0.DAT_B), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.FRAME_SYNC = 1;
    @(posedge clk); #1;
    chk("post.upd", 64'(bus0.UPDATED), 64'h0);
    chk("post.arm", 64'(bus0.ARMED), 64'h0);
    @(negedge clk);
    bus0.FRAME_SYNC = 0;
    @(posedge clk); #1;
    chk("post2.upd", 64'(bus0.UPDATED), 64'h0);
    chk("post2.act", bus0.ACTIVE, RV0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cfg_regbank_sync.md
Name: cfg_regbank_sync

Overview:
- Parametrised, double-buffered configuration register bank. It succeeds the fixed 4x16 byte-write/word-read register file used to configure the sensor interface.
- The host writes bytes into a staging bank. Staged words transfer to the active bank either immediately or on a frame-synchronous commit, so sensor timing fields (MCLK speed/mode, row delay, idle) never change mid-frame.
- Sits between the host byte-register bus and the sensor interface / MCLK generator. Active bank is exported flattened; a word read-back port serves either bank.

Parameters:
- NUM_REGS, 4, number of words; must be at least 2.
- REG_W, 16, word width; must be a multiple of 8. BYTES = REG_W/8.
- ADDR_A_W, 3, byte-address width; must satisfy 2^ADDR_A_W >= NUM_REGS*BYTES.
- ADDR_B_W, 2, word-address width; must satisfy 2^ADDR_B_W >= NUM_REGS.
- SYNC_MODE, 1, update policy: 0 = staged writes reach the active bank the next cycle; 1 = staged writes reach the active bank only on a frame-synchronous commit.
- RESET_VAL, all zeros, NUM_REGS*REG_W vector of reset values; word i occupies bits [i*REG_W +: REG_W].

Ports:
- CLOCK  in  1  system clock (48 MHz)
- RESET_N  in  1  asynchronous active-low reset
- WE_A  in  1  byte write strobe
- ADD_A  in  ADDR_A_W  byte address
- DAT_A  in  8  write byte
- RE_B  in  1  word read strobe
- SEL_B  in  1  read source: 0 = active bank, 1 = staging bank
- ADD_B  in  ADDR_B_W  word address
- DAT_B  out  REG_W  read data
- VALID_B  out  1  read data valid
- COMMIT  in  1  host commit request pulse; ignored when SYNC_MODE=0
- FRAME_SYNC  in  1  frame boundary pulse from the sensor interface
- ARMED  out  1  commit pending
- UPDATED  out  1  one-cycle pulse when the active bank is loaded
- DIRTY  out  NUM_REGS  per-word flag: staged word differs in origin from active (written since last transfer)
- ACTIVE  out  NUM_REGS*REG_W  flattened active bank

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - staging and active banks = RESET_VAL
  - DAT_B = 0; VALID_B = 0; ARMED = 0; UPDATED = 0; DIRTY = 0
- Byte mapping:
  - word = ADD_A / BYTES, lane = ADD_A % BYTES.
  - lane 0 is the most significant byte. For REG_W=16, even addresses hit [15:8] and odd addresses hit [7:0].
  - A write updates only its lane in the staging word and sets DIRTY[word].
  - Writes with word >= NUM_REGS are ignored: no state change.
- Read port:
  - RE_B registers DAT_B = bank[SEL_B][ADD_B] with 1-cycle latency; VALID_B is high in that same cycle.
  - Without RE_B, DAT_B holds its value and VALID_B = 0.
  - ADD_B >= NUM_REGS returns 0 with VALID_B = 1.
  - A read in the same cycle as a write or transfer returns the pre-edge contents.
- SYNC_MODE=0:
  - Every dirty word is copied to active on the next cycle and its DIRTY bit is cleared.
  - UPDATED pulses on that copy cycle.
  - ARMED is constant 0.
- SYNC_MODE=1 FSM:
  - IDLE: COMMIT -> ARMED. If FRAME_SYNC is high in the same cycle, the transfer happens immediately and the FSM stays in IDLE.
  - ARMED: FRAME_SYNC -> XFER. COMMIT while ARMED has no effect.
  - XFER: lasts one cycle.
    - Every word with DIRTY set copies staging to active, and those DIRTY bits clear.
    - UPDATED = 1.
    - Then return to IDLE.
  - Implementation may merge XFER into the FRAME_SYNC edge. UPDATED latency is fixed at 1 cycle after the FRAME_SYNC sample.
- Simultaneous write and transfer:
  - The copy uses the pre-edge staging value.
  - The written word keeps DIRTY = 1 and goes in the next commit.
- FRAME_SYNC while IDLE: no effect.
- COMMIT with no dirty words: still arms. The transfer copies nothing and UPDATED still pulses.
- Reset mid-ARMED: the FSM aborts to IDLE; both banks return to RESET_VAL.

Decomposition:
- Shared package cfg_regbank_pkg holds:
  - FSM state encoding (IDLE, ARMED, XFER)
  - SYNC_MODE constants
  - field-position localparams for the sensor config word: MCLK_SPEED bit 0, IDLE_MODE bit 1, MCLK_MODE [7:6], ROWS_DELAY [15:11]
  - consumers slice ACTIVE using these localparams
- One natural sub-module, cfg_commit_fsm: ARMED/XFER control, producing the transfer enable and UPDATED.

Test Plan (NUM_REGS=4, REG_W=16, SYNC_MODE=1 unless noted):
- Reset-value check: RESET_VAL word1 = 0x8841; release reset -> ACTIVE word1 = 0x8841, DIRTY = 0, DAT_B = 0, VALID_B = 0.
- Staged write without commit:
  - stimulus: write ADD_A=2 <- 0xA5, ADD_A=3 <- 0x3C
  - staging read (SEL_B=1, ADD_B=1) -> 0xA53C, VALID_B one cycle after RE_B
  - active read (SEL_B=0, ADD_B=1) -> 0x8841
  - DIRTY = 4'b0010
- Frame-synchronous commit: after the write above, COMMIT, wait 3 cycles, FRAME_SYNC -> ARMED = 1 until the transfer, UPDATED pulse 1 cycle after FRAME_SYNC, ACTIVE word1 = 0xA53C, DIRTY = 0.
- Collision: while ARMED, write ADD_A=3 <- 0xFF in the same cycle as FRAME_SYNC -> ACTIVE word1 = 0xA53C, staging word1 = 0xA5FF, DIRTY[1] = 1.
- Out-of-range and mode checks:
  - write ADD_A=7 <- 0x12 (word 3 is valid, lane 1) -> staging word3 = 0x0012
  - NUM_REGS=3 build: the same write is ignored
  - read ADD_B=3 on the NUM_REGS=3 build -> DAT_B = 0, VALID_B = 1
  - SYNC_MODE=0 build: write ADD_A=0 <- 0x55 -> ACTIVE word0 = 0x5500 the next cycle, with UPDATED pulsing
- Reset while ARMED: assert RESET_N=0 asynchronously -> ARMED = 0 and ACTIVE = RESET_VAL immediately; a later FRAME_SYNC gives no UPDATED.
